sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between instruction fetch and
// load/store. Data wins ties after reset; a fetch that loses a contended
// cycle is guaranteed to win the next one. Read data returns one cycle after
// the grant and is steered to whichever side issued the read.
module sram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        stallreq_inst,
    output logic        stallreq_data,
    output logic [31:0] conflict_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } own_e;

    logic        prio_inst_q, prio_inst_d;
    own_e        resp_own_q, resp_own_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    logic        grant_inst;
    logic        grant_data;
    logic        contended;

    // Grant decision, SRAM drive, stalls and next-state for all registers.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        grant_inst     = 1'b0;
        grant_data     = 1'b0;
        contended      = 1'b0;
        mem_en         = 1'b0;
        mem_wen        = 4'b0000;
        mem_addr       = 32'h0;
        mem_wdata      = 32'h0;
        stallreq_inst  = 1'b0;
        stallreq_data  = 1'b0;
        prio_inst_d    = prio_inst_q;
        resp_own_d     = OWN_NONE;
        conflict_cnt_d = conflict_cnt_q;

        if (!rst) begin
            // Only one requester can win; prio_inst breaks ties.
            if (mem_ready) begin
                if (inst_req && (!data_req || prio_inst_q)) begin
                    grant_inst = 1'b1;
                end else if (data_req) begin
                    grant_data = 1'b1;
                end
            end

            contended = inst_req && data_req && mem_ready;

            if (grant_inst) begin
                mem_en    = 1'b1;
                mem_addr  = inst_addr;
            end else if (grant_data) begin
                mem_en    = 1'b1;
                mem_wen   = data_wen;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end

            stallreq_inst = inst_req && !grant_inst;
            stallreq_data = data_req && !grant_data;

            // A fetch that loses gets priority next time; any fetch grant
            // hands priority back to data.
            if (grant_inst) begin
                prio_inst_d = 1'b0;
            end else if (grant_data && inst_req) begin
                prio_inst_d = 1'b1;
            end

            // Writes return nothing, so only reads claim the response slot.
            if (grant_inst) begin
                resp_own_d = OWN_INST;
            end else if (grant_data && (data_wen == 4'b0000)) begin
                resp_own_d = OWN_DATA;
            end

            if (contended && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
                conflict_cnt_d = conflict_cnt_q + 32'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            prio_inst_q    <= 1'b0;
            resp_own_q     <= OWN_NONE;
            conflict_cnt_q <= 32'h0;
        end else begin
            prio_inst_q    <= prio_inst_d;
            resp_own_q     <= resp_own_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Return-path steering; gated by rst so a read granted just before
    // reset never surfaces.
    always_comb begin
        inst_rvalid = !rst && (resp_own_q == OWN_INST);
        data_rvalid = !rst && (resp_own_q == OWN_DATA);
        inst_rdata  = inst_rvalid ? mem_rdata : 32'h0;
        data_rdata  = data_rvalid ? mem_rdata : 32'h0;
    end

    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors for sram_arbiter. Each step drives one
// cycle of requests and checks the combinational grant side; expected read
// returns go into a scoreboard queue that a separate monitor drains.
module tb_sram_arbiter;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    localparam int OWN_NONE = 0;
    localparam int OWN_INST = 1;
    localparam int OWN_DATA = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = 4'b0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        stallreq_inst;
    logic        stallreq_data;
    logic [31:0] conflict_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        int          own;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    sram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .data_req      (data_req),
        .data_wen      (data_wen),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .mem_ready     (mem_ready),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .inst_rdata    (inst_rdata),
        .inst_rvalid   (inst_rvalid),
        .data_rdata    (data_rdata),
        .data_rvalid   (data_rvalid),
        .stallreq_inst (stallreq_inst),
        .stallreq_data (stallreq_data),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter used to date scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: an accepted read returns address ^ KEY one cycle later;
    // otherwise the bus carries junk that must not leak to the requesters.
    always @(posedge clk) begin
        if (mem_en && (mem_wen == 4'b0000)) mem_rdata <= mem_addr ^ KEY;
        else                                mem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected response whenever a return is due or seen.
    always begin
        @(negedge clk);
        #1;
        while (sb_q.size() != 0 && sb_q[0].due < cyc) begin
            check("stale_response", 32'(sb_q[0].own), 32'(OWN_NONE));
            void'(sb_q.pop_front());
        end
        if (inst_rvalid || data_rvalid) begin
            if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
                check("unexpected_rvalid", {30'h0, data_rvalid, inst_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rvalid_owner", {30'h0, data_rvalid, inst_rvalid},
                      (e.own == OWN_DATA) ? 32'h2 : 32'h1);
                check("rdata", inst_rvalid ? inst_rdata : data_rdata, e.data);
            end
        end else if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            check("missing_rvalid", 32'h0, 32'(sb_q[0].own));
            void'(sb_q.pop_front());
        end
        if (!inst_rvalid) check("inst_rdata_idle", inst_rdata, 32'h0);
        if (!data_rvalid) check("data_rdata_idle", data_rdata, 32'h0);
    end

    // One cycle: drive inputs at negedge, log the expected return, then
    // check the combinational grant outputs and the counter.
    task automatic step(
        input string       tag,
        input logic        r,
        input logic        ir,
        input logic [31:0] ia,
        input logic        dr,
        input logic [3:0]  dw,
        input logic [31:0] da,
        input logic [31:0] dwd,
        input logic        mr,
        input logic        e_en,
        input logic [3:0]  e_wen,
        input logic [31:0] e_addr,
        input logic [31:0] e_wd,
        input logic        e_si,
        input logic        e_sd,
        input logic [31:0] e_cnt,
        input int          e_own
    );
        @(negedge clk);
        rst        = r;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wen   = dw;
        data_addr  = da;
        data_wdata = dwd;
        mem_ready  = mr;
        if (e_own != OWN_NONE) sb_q.push_back('{e_own, e_addr ^ KEY, cyc + 1});
        #1;
        check({tag, ".mem_en"},        {31'h0, mem_en},        {31'h0, e_en});
        check({tag, ".mem_wen"},       {28'h0, mem_wen},       {28'h0, e_wen});
        check({tag, ".mem_addr"},      mem_addr,               e_addr);
        check({tag, ".mem_wdata"},     mem_wdata,              e_wd);
        check({tag, ".stallreq_inst"}, {31'h0, stallreq_inst}, {31'h0, e_si});
        check({tag, ".stallreq_data"}, {31'h0, stallreq_data}, {31'h0, e_sd});
        check({tag, ".conflict_cnt"},  conflict_cnt,           e_cnt);
    endtask

    localparam logic [31:0] IA0 = 32'hBFC0_0000;
    localparam logic [31:0] DA0 = 32'h8000_0010;
    localparam logic [31:0] WD0 = 32'h1234_5678;

    initial begin
        //     tag        rst ir ia            dr dw     da            dwd  mr | en wen    addr          wdata si sd cnt            own
        step("rst0",      1, 1, IA0,          1, 4'h0, DA0,          0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'h0,         OWN_NONE);
        step("rst1",      1, 1, IA0,          1, 4'h0, DA0,          0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'h0,         OWN_NONE);
        // First cycle out of reset: data has priority.
        step("conf1",     0, 1, IA0,          1, 4'h0, DA0,          0,   1,   1, 4'h0, DA0,          0,   1, 0, 32'h0,         OWN_DATA);
        step("conf2",     0, 1, IA0,          1, 4'h0, DA0,          0,   1,   1, 4'h0, IA0,          0,   0, 1, 32'h1,         OWN_INST);
        step("fetch",     0, 1, 32'hBFC0_0004, 0, 4'h0, 32'h0,        0,   1,   1, 4'h0, 32'hBFC0_0004, 0,   0, 0, 32'h2,         OWN_INST);
        // Store: byte enables and data pass through, no return.
        step("store",     0, 0, 32'h0,        1, 4'hF, 32'h8000_0020, WD0, 1,   1, 4'hF, 32'h8000_0020, WD0, 0, 0, 32'h2,         OWN_NONE);
        step("idle0",     0, 0, 32'h0,        0, 4'h0, 32'h0,        0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'h2,         OWN_NONE);
        // Data wins, then SRAM busy for three cycles; inst must win after.
        step("conf3",     0, 1, 32'hBFC0_0008, 1, 4'h0, 32'h8000_0030, 0,   1,   1, 4'h0, 32'h8000_0030, 0,   1, 0, 32'h2,         OWN_DATA);
        step("busy0",     0, 1, 32'hBFC0_0008, 1, 4'h0, 32'h8000_0030, 0,   0,   0, 4'h0, 32'h0,        0,   1, 1, 32'h3,         OWN_NONE);
        step("busy1",     0, 1, 32'hBFC0_0008, 1, 4'h0, 32'h8000_0030, 0,   0,   0, 4'h0, 32'h0,        0,   1, 1, 32'h3,         OWN_NONE);
        step("busy2",     0, 1, 32'hBFC0_0008, 1, 4'h0, 32'h8000_0030, 0,   0,   0, 4'h0, 32'h0,        0,   1, 1, 32'h3,         OWN_NONE);
        step("resume",    0, 1, 32'hBFC0_0008, 1, 4'h0, 32'h8000_0030, 0,   1,   1, 4'h0, 32'hBFC0_0008, 0,   0, 1, 32'h3,         OWN_INST);
        step("dread",     0, 0, 32'h0,        1, 4'h0, 32'h8000_0030, 0,   1,   1, 4'h0, 32'h8000_0030, 0,   0, 0, 32'h4,         OWN_DATA);
        // Fetch granted, then reset: its return must be suppressed.
        step("rstread",   0, 1, 32'hBFC0_000C, 0, 4'h0, 32'h0,        0,   1,   1, 4'h0, 32'hBFC0_000C, 0,   0, 0, 32'h4,         OWN_NONE);
        step("rst2",      1, 1, IA0,          1, 4'h0, DA0,          0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'h4,         OWN_NONE);
        step("postrst",   0, 0, 32'h0,        0, 4'h0, 32'h0,        0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'h0,         OWN_NONE);
        // Saturation: preload near the top, then contend three times.
        force dut.conflict_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt_q;
        step("sat0",      0, 1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_0040, 0,   1,   1, 4'h0, 32'h8000_0040, 0,   1, 0, 32'hFFFF_FFFE, OWN_DATA);
        step("sat1",      0, 1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_0040, 0,   1,   1, 4'h0, 32'hBFC0_0010, 0,   0, 1, 32'hFFFF_FFFF, OWN_INST);
        step("sat2",      0, 1, 32'hBFC0_0010, 1, 4'h0, 32'h8000_0040, 0,   1,   1, 4'h0, 32'h8000_0040, 0,   1, 0, 32'hFFFF_FFFF, OWN_DATA);
        step("idle1",     0, 0, 32'h0,        0, 4'h0, 32'h0,        0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'hFFFF_FFFF, OWN_NONE);
        step("idle2",     0, 0, 32'h0,        0, 4'h0, 32'h0,        0,   1,   0, 4'h0, 32'h0,        0,   0, 0, 32'hFFFF_FFFF, OWN_NONE);
        @(negedge clk);
        #2;
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
